retire_monitor: RTL and testbench
=================================

// Module: retire_monitor
// PURPOSE
//   Synthesizable commit-side monitor downstream of the singlecycle/pipelined core.
//   Consumes the core's pc-debug and insn-valid strobes and counts retired instructions,
//   run cycles and bubbles. Detects end-of-program (self-loop `j .`) and runaway execution.
//   Keeps a circular trace of the last TRACE_DEPTH retired PCs for the scoreboard and FPGA debug.
// PARAMETERS
//   PC_W           32      width of pc_debug_i and trace entries
//   TRACE_DEPTH    16      trace entries; power of 2, >=2
//   HALT_CYCLES    8       consecutive same-PC valid retires that declare halt; >=2
//   TIMEOUT_CYCLES 100000  RUN-state cycles before timeout; >=1
// PORTS
//   clk_i           in   1                   core clock
//   rst_ni          in   1                   async active-low reset
//   pc_debug_i      in   PC_W                PC of instruction completing this cycle
//   insn_vld_i      in   1                   1 = pc_debug_i is a real retire, 0 = bubble
//   trace_rd_idx_i  in   $clog2(TRACE_DEPTH) 0 = newest entry, 1 = previous, ...
//   trace_rd_data_o out  PC_W                registered trace read data
//   trace_cnt_o     out  $clog2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH
//   retired_cnt_o   out  32                  valid retires since leaving IDLE
//   cycle_cnt_o     out  32                  cycles spent in RUN
//   bubble_cnt_o    out  32                  RUN cycles with insn_vld_i=0 (see CONFIGURATION)
//   state_o         out  2                   00 IDLE, 01 RUN, 10 HALT, 11 TIMEOUT
//   halted_o        out  1                   sticky; state==HALT
//   timeout_o       out  1                   sticky; state==TIMEOUT
// BEHAVIOUR
//   Reset (rst_ni=0, async): state IDLE; every output and counter 0; trace_cnt 0.
//     Trace RAM need not be cleared; trace_cnt masks stale entries.
//   A retire is an edge sampling insn_vld_i=1 in IDLE or RUN. Effects are visible the following cycle.
//   IDLE -> RUN on the first retire. That retire is counted (retired_cnt=1) and traced.
//   RUN, per edge:
//     cycle_cnt += 1.
//     On a retire: retired_cnt += 1; write the PC to trace[wr_ptr]; wr_ptr += 1 mod DEPTH.
//     rep_cnt: a retire with PC == last retired PC increments it.
//       A retire with a different PC clears it to 0. Bubbles leave it unchanged.
//     rep_cnt reaching HALT_CYCLES-1 (i.e., HALT_CYCLES identical retires) -> HALT.
//       The halting retire itself is counted and traced.
//     cycle_cnt becoming TIMEOUT_CYCLES -> TIMEOUT.
//     If halt and timeout occur on the same edge, HALT wins.
//   HALT and TIMEOUT are terminal until reset. All counters and the trace are frozen,
//     and inputs are ignored.
//   All 32-bit counters saturate at 32'hFFFF_FFFF; no wrap-around.
//   Trace read: 1-cycle latency. trace_rd_data_o <= trace[(wr_ptr-1-idx) mod DEPTH].
//     It returns 0 when idx >= trace_cnt.
//     A read and a write on the same edge return the pre-write buffer state.
//   Trace overflow: the oldest entry is overwritten and trace_cnt stays at TRACE_DEPTH.
//   Reset mid-operation: immediate return to IDLE with all outputs 0.
//     The next retire restarts monitoring.
// CONFIGURATION
//   RETIRE_MONITOR_BUBBLE_CNT_EN defined: bubble_cnt_o counts RUN-state edges with
//     insn_vld_i=0. It saturates and freezes in HALT/TIMEOUT.
//   Undefined: no bubble counter logic; bubble_cnt_o tied to 32'h0. The port always exists.
// TESTING
//   1 Reset: rst_ni=0 for 15 time units, inputs random -> all outputs 0, state_o=00.
//   2 Straight line: 16 retires, pc 0x0,0x4..0x3C, no bubbles -> retired_cnt=16, cycle_cnt=15,
//     trace_cnt=16, idx0 -> 0x3C, idx15 -> 0x0 (next cycle).
//   3 Halt: retires pc 0x0,0x4, then pc 0x40 x8 with 2 bubbles between them -> halted_o=1
//     the cycle after the 8th 0x40, retired_cnt=10, bubble_cnt=2 (EN) / 0 (no EN), counters frozen.
//   4 Timeout (TIMEOUT_CYCLES=50): ever-incrementing pc every cycle -> timeout_o=1 after the
//     50th RUN edge, cycle_cnt=50, retired_cnt=51.
//   5 Wrap: 20 retires, pc 0x0..0x4C -> trace_cnt=16, idx0 -> 0x4C, idx15 -> 0x10; read of
//     idx3 with trace_cnt=2 earlier -> 0.
//   6 Reset mid-RUN after 5 retires -> outputs 0 and IDLE asynchronously; 3 new retires ->
//     retired_cnt=3, trace_cnt=3.

Source files
------------

// File: rtl/retire_monitor.sv
// Commit-side retire monitor: counts retires/cycles, detects halt (self-loop) and timeout, keeps a PC trace.
// Optional bubble counter enabled by defining RETIRE_MONITOR_BUBBLE_CNT_EN.
module retire_monitor #(
    parameter int unsigned PC_W           = 32,
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter int unsigned HALT_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [PC_W-1:0]                  pc_debug_i,
    input  logic                             insn_vld_i,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_rd_idx_i,
    output logic [PC_W-1:0]                  trace_rd_data_o,
    output logic [$clog2(TRACE_DEPTH):0]     trace_cnt_o,
    output logic [31:0]                      retired_cnt_o,
    output logic [31:0]                      cycle_cnt_o,
    output logic [31:0]                      bubble_cnt_o,
    output logic [1:0]                       state_o,
    output logic                             halted_o,
    output logic                             timeout_o
);
    localparam int unsigned AW = $clog2(TRACE_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = $clog2(HALT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HALT    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     retired_cnt_q, retired_cnt_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic [CW-1:0]   trace_cnt_q, trace_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic [PC_W-1:0] rd_data_q;
    logic [PC_W-1:0] trace_mem [TRACE_DEPTH];
    logic            trace_we;
    logic [AW-1:0]   rd_addr;
    logic            rd_hit;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        retired_cnt_d = retired_cnt_q;
        cycle_cnt_d   = cycle_cnt_q;
        trace_cnt_d   = trace_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rep_cnt_d     = rep_cnt_q;
        last_pc_d     = last_pc_q;
        trace_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (insn_vld_i) begin
                    state_d       = ST_RUN;
                    retired_cnt_d = 32'd1;
                    trace_we      = 1'b1;
                    wr_ptr_d      = wr_ptr_q + AW'(1);
                    trace_cnt_d   = CW'(1);
                    last_pc_d     = pc_debug_i;
                    rep_cnt_d     = '0;
                end
            end
            ST_RUN: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
                if (insn_vld_i) begin
                    retired_cnt_d = sat_inc(retired_cnt_q);
                    trace_we      = 1'b1;
                    wr_ptr_d      = wr_ptr_q + AW'(1);
                    trace_cnt_d   = (trace_cnt_q == CW'(TRACE_DEPTH)) ? trace_cnt_q
                                                                      : trace_cnt_q + CW'(1);
                    last_pc_d     = pc_debug_i;
                    rep_cnt_d     = (pc_debug_i == last_pc_q) ? rep_cnt_q + RW'(1) : '0;
                end
                // Halt takes priority over a timeout landing on the same edge.
                if (insn_vld_i && rep_cnt_d == RW'(HALT_CYCLES - 1)) begin
                    state_d = ST_HALT;
                end else if (cycle_cnt_d == 32'(TIMEOUT_CYCLES)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_addr = wr_ptr_q - AW'(1) - trace_rd_idx_i;
        rd_hit  = {1'b0, trace_rd_idx_i} < trace_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            retired_cnt_q <= '0;
            cycle_cnt_q   <= '0;
            trace_cnt_q   <= '0;
            wr_ptr_q      <= '0;
            rep_cnt_q     <= '0;
            last_pc_q     <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            retired_cnt_q <= retired_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
            trace_cnt_q   <= trace_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rep_cnt_q     <= rep_cnt_d;
            last_pc_q     <= last_pc_d;
            rd_data_q     <= rd_hit ? trace_mem[rd_addr] : '0;
        end
    end

    // Trace RAM is left uninitialised; trace_cnt masks stale entries.
    always_ff @(posedge clk_i) begin
        if (trace_we) begin
            trace_mem[wr_ptr_q] <= pc_debug_i;
        end
    end

`ifdef RETIRE_MONITOR_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (state_q == ST_RUN && !insn_vld_i) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign bubble_cnt_o = '0;
`endif

    assign trace_rd_data_o = rd_data_q;
    assign trace_cnt_o     = trace_cnt_q;
    assign retired_cnt_o   = retired_cnt_q;
    assign cycle_cnt_o     = cycle_cnt_q;
    assign state_o         = state_q;
    assign halted_o        = (state_q == ST_HALT);
    assign timeout_o       = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: queue-based reference model checked every cycle, directed scenarios plus random episodes.
module tb_retire_monitor;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned HALTN = 8;
    localparam int unsigned TMO   = 50;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        vld;
    logic [3:0]  idx;
    logic [31:0] rd_data;
    logic [4:0]  tcnt;
    logic [31:0] ret_cnt, cyc_cnt, bub_cnt;
    logic [1:0]  state;
    logic        halted, tmo;

    int total = 0;
    int bad   = 0;

    retire_monitor #(
        .PC_W(PC_W), .TRACE_DEPTH(DEPTH), .HALT_CYCLES(HALTN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_debug_i(pc), .insn_vld_i(vld),
        .trace_rd_idx_i(idx), .trace_rd_data_o(rd_data), .trace_cnt_o(tcnt),
        .retired_cnt_o(ret_cnt), .cycle_cnt_o(cyc_cnt), .bubble_cnt_o(bub_cnt),
        .state_o(state), .halted_o(halted), .timeout_o(tmo)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Reference model: trace is a queue with newest entry at index 0.
    logic [1:0]  m_state = 2'd0;
    logic [31:0] m_ret = 0, m_cyc = 0, m_bub = 0, m_rd = 0, m_last = 0;
    int          m_same = 0;
    logic [31:0] m_tr[$];

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0; m_ret = 0; m_cyc = 0; m_bub = 0; m_rd = 0; m_last = 0; m_same = 0;
                m_tr.delete();
            end else begin
                m_rd = (int'(idx) < m_tr.size()) ? m_tr[idx] : 32'd0;
                if (m_state == 2'd0) begin
                    if (vld) begin
                        m_state = 2'd1; m_ret = 1; m_last = pc; m_same = 1;
                        m_tr.push_front(pc);
                    end
                end else if (m_state == 2'd1) begin
                    m_cyc = sat(m_cyc);
                    if (vld) begin
                        m_ret = sat(m_ret);
                        m_tr.push_front(pc);
                        if (m_tr.size() > DEPTH) void'(m_tr.pop_back());
                        m_same = (pc == m_last) ? m_same + 1 : 1;
                        m_last = pc;
                    end else begin
                        m_bub = sat(m_bub);
                    end
                    if (vld && m_same == HALTN) m_state = 2'd2;
                    else if (m_cyc == TMO) m_state = 2'd3;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_bub(input logic [31:0] b);
`ifdef RETIRE_MONITOR_BUBBLE_CNT_EN
        return b;
`else
        return (b == 32'hFFFF_FFFF) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("state", 64'(state), 64'(m_state));
            chk("halted", 64'(halted), 64'(m_state == 2'd2));
            chk("timeout", 64'(tmo), 64'(m_state == 2'd3));
            chk("retired", 64'(ret_cnt), 64'(m_ret));
            chk("cycles", 64'(cyc_cnt), 64'(m_cyc));
            chk("bubbles", 64'(bub_cnt), 64'(exp_bub(m_bub)));
            chk("trace_cnt", 64'(tcnt), 64'(m_tr.size()));
            chk("rd_data", 64'(rd_data), 64'(m_rd));
        end
    end

    task automatic cyc(input logic v, input logic [31:0] p, input logic [3:0] i);
        vld = v; pc = p; idx = i;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        vld = 1'($urandom); pc = $urandom;
        @(negedge clk);
        rst_n = 1'b1; vld = 1'b0;
    endtask

    logic [31:0] cur;

    initial begin
        rst_n = 1'b0; vld = 1'($urandom); pc = $urandom; idx = 4'($urandom);
        repeat (4) begin
            #3 vld = 1'($urandom); pc = $urandom; idx = 4'($urandom);
        end
        #2;
        chk("rst_state", 64'(state), 0);
        chk("rst_retired", 64'(ret_cnt), 0);
        chk("rst_tcnt", 64'(tcnt), 0);
        chk("rst_rd", 64'(rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1; vld = 1'b0;

        // Straight-line program
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i * 4), 4'd0);
        chk("sl_retired", 64'(ret_cnt), 16);
        chk("sl_cycles", 64'(cyc_cnt), 15);
        chk("sl_tcnt", 64'(tcnt), 16);
        chk("sl_model_ret", 64'(m_ret), 16);
        cyc(1'b0, 32'd0, 4'd0);
        chk("sl_idx0", 64'(rd_data), 64'h3C);
        cyc(1'b0, 32'd0, 4'd15);
        chk("sl_idx15", 64'(rd_data), 64'h0);

        // Halt on self-loop with bubbles interleaved
        do_reset();
        cyc(1'b1, 32'h0, 4'd0);
        cyc(1'b1, 32'h4, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 32'h40, 4'd0);
            if (k == 3 || k == 5) cyc(1'b0, 32'h40, 4'd0);
            if (k == 7) chk("halt_early", 64'(halted), 0);
        end
        chk("halt_flag", 64'(halted), 1);
        chk("halt_retired", 64'(ret_cnt), 10);
`ifdef RETIRE_MONITOR_BUBBLE_CNT_EN
        chk("halt_bubbles", 64'(bub_cnt), 2);
`else
        chk("halt_bubbles", 64'(bub_cnt), 0);
`endif
        chk("halt_cycles", 64'(cyc_cnt), 11);
        chk("halt_model_state", 64'(m_state), 2);
        repeat (5) cyc(1'($urandom), $urandom, 4'($urandom));
        chk("halt_frozen_ret", 64'(ret_cnt), 10);
        chk("halt_frozen_cyc", 64'(cyc_cnt), 11);

        // Timeout on runaway execution
        do_reset();
        cyc(1'b1, 32'h0, 4'd0);
        for (int i = 1; i <= 50; i++) begin
            cyc(1'b1, 32'(i * 4), 4'd0);
            if (i == 49) chk("tmo_early", 64'(tmo), 0);
        end
        chk("tmo_flag", 64'(tmo), 1);
        chk("tmo_cycles", 64'(cyc_cnt), 50);
        chk("tmo_retired", 64'(ret_cnt), 51);
        repeat (3) cyc(1'b1, $urandom, 4'($urandom));
        chk("tmo_frozen", 64'(ret_cnt), 51);

        // Trace wrap and masking of stale entries
        do_reset();
        cyc(1'b1, 32'h0, 4'd3);
        cyc(1'b1, 32'h4, 4'd3);
        cyc(1'b1, 32'h8, 4'd3);
        chk("wrap_idx3_cnt2", 64'(rd_data), 0);
        for (int i = 3; i < 20; i++) cyc(1'b1, 32'(i * 4), 4'd0);
        chk("wrap_tcnt", 64'(tcnt), 16);
        cyc(1'b0, 32'd0, 4'd0);
        chk("wrap_idx0", 64'(rd_data), 64'h4C);
        cyc(1'b0, 32'd0, 4'd15);
        chk("wrap_idx15", 64'(rd_data), 64'h10);

        // Asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(32'h100 + i * 4), 4'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(state), 0);
        chk("arst_retired", 64'(ret_cnt), 0);
        chk("arst_tcnt", 64'(tcnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h200 + i * 4), 4'd0);
        chk("arst_new_ret", 64'(ret_cnt), 3);
        chk("arst_new_tcnt", 64'(tcnt), 3);
        cyc(1'b0, 32'd0, 4'd2);
        chk("arst_idx2", 64'(rd_data), 64'h200);

        // Random episodes: sticky PCs provoke halts, long runs provoke timeouts
        for (int e = 0; e < 10; e++) begin
            do_reset();
            cur = 32'h0;
            for (int c = 0; c < 70; c++) begin
                if ($urandom_range(0, 63) == 0) begin
                    do_reset();
                end else begin
                    if ($urandom_range(0, 3) == 0) cur = 32'($urandom_range(0, 3) * 4);
                    cyc(1'($urandom_range(0, 3) != 0), cur, 4'($urandom));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
